// File: rtl/spi_slave_core_if.sv
// Host and SPI pin bundle for spi_slave_core.
// The slave modport is the core's view; the master modport drives pins and the TX buffer.
interface spi_slave_core_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_cpol;
  logic                  i_cpha;
  logic                  i_sclk;
  logic                  i_ss_n;
  logic                  i_mosi;
  logic                  o_miso;
  logic                  o_miso_en;
  logic [DATA_WIDTH-1:0] i_tx_data;
  logic                  i_tx_valid;
  logic                  o_tx_rdy;
  logic [DATA_WIDTH-1:0] o_rx_data;
  logic                  o_rx_valid;
  logic                  o_underrun;
  logic                  o_busy;

  modport slave (
    input  i_cpol, i_cpha, i_sclk, i_ss_n, i_mosi, i_tx_data, i_tx_valid,
    output o_miso, o_miso_en, o_tx_rdy, o_rx_data, o_rx_valid, o_underrun, o_busy
  );

  modport master (
    output i_cpol, i_cpha, i_sclk, i_ss_n, i_mosi, i_tx_data, i_tx_valid,
    input  o_miso, o_miso_en, o_tx_rdy, o_rx_data, o_rx_valid, o_underrun, o_busy
  );
endinterface

// File: rtl/spi_slave_core.sv
// SPI responder: oversamples SCLK/SS_n/MOSI on clk, shifts words MSB first in all
// four CPOL/CPHA modes, with a single-word TX buffer and a one-cycle RX strobe.
module spi_slave_core #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  spi_slave_core_if.slave bus
);

  localparam int            CW        = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
  localparam logic [0:0]    ST_IDLE   = 1'b0;
  localparam logic [0:0]    ST_ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
  logic                   sclk_dly, ss_dly;
  logic [0:0]             state;
  logic                   cpol_q, cpha_q;
  logic [CW-1:0]          bit_cnt;
  logic [DATA_WIDTH-2:0]  rx_shift;
  logic [DATA_WIDTH-1:0]  tx_shift, tx_buf, rx_data;
  logic                   tx_full, miso, rx_valid, underrun;

  logic sclk_s, ss_s, mosi_s;
  logic sclk_rise, sclk_fall, leading, trailing, sample_edge, shift_edge;
  logic ss_fall, ss_rise, word_done, load, load_cpha, tx_wr, shift_ok;
  logic [DATA_WIDTH-1:0] load_word, rx_next;

  // Input synchronisers plus one extra delay flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      ss_sync   <= '1;
      mosi_sync <= '0;
      sclk_dly  <= 1'b0;
      ss_dly    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.i_sclk};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.i_ss_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.i_mosi};
      sclk_dly  <= sclk_sync[SYNC_STAGES-1];
      ss_dly    <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign ss_s      = ss_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_dly;
  assign sclk_fall = ~sclk_s & sclk_dly;
  assign ss_fall   = ~ss_s & ss_dly;
  assign ss_rise   = ss_s & ~ss_dly;

  // Leading edge leaves the idle level; mode bits are the ones latched at select.
  assign leading     = cpol_q ? sclk_fall : sclk_rise;
  assign trailing    = cpol_q ? sclk_rise : sclk_fall;
  assign sample_edge = cpha_q ? trailing : leading;
  assign shift_edge  = cpha_q ? leading : trailing;

  // CPHA=0 preloads the MSB, so the trailing edge right after a word boundary is skipped.
  assign shift_ok  = cpha_q | (bit_cnt != '0);
  assign word_done = (state == ST_ACTIVE) & ~ss_rise & sample_edge & (bit_cnt == LAST_BIT);
  assign load      = ((state == ST_IDLE) & ss_fall) | word_done;
  assign load_cpha = (state == ST_IDLE) ? bus.i_cpha : cpha_q;
  assign load_word = tx_full ? tx_buf : '0;
  assign tx_wr     = bus.i_tx_valid & ~tx_full;
  assign rx_next   = {rx_shift, mosi_s};

  // NOTE: tx_buf holds data only; tx_full says whether it is meaningful, so it needs no reset.
  always_ff @(posedge clk) begin
    if (tx_wr) tx_buf <= bus.i_tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      tx_full  <= 1'b0;
      miso     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      underrun <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      underrun <= load & ~tx_full;
      // A load sees the old buffer; a write in the same cycle refills it.
      tx_full  <= tx_wr | (tx_full & ~load);

      if (state == ST_IDLE) begin
        miso <= 1'b0;
        if (ss_fall) begin
          state   <= ST_ACTIVE;
          cpol_q  <= bus.i_cpol;
          cpha_q  <= bus.i_cpha;
          bit_cnt <= '0;
        end
      end else if (ss_rise) begin
        state   <= ST_IDLE;
        miso    <= 1'b0;
        bit_cnt <= '0;
      end else begin
        if (sample_edge) begin
          rx_shift <= rx_next[DATA_WIDTH-2:0];
          if (bit_cnt == LAST_BIT) begin
            rx_data  <= rx_next;
            rx_valid <= 1'b1;
            bit_cnt  <= '0;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        if (shift_edge && shift_ok) begin
          miso     <= tx_shift[DATA_WIDTH-1];
          tx_shift <= tx_shift << 1;
        end
      end

      if (load) begin
        if (load_cpha) begin
          tx_shift <= load_word;
        end else begin
          miso     <= load_word[DATA_WIDTH-1];
          tx_shift <= load_word << 1;
        end
      end
    end
  end

  assign bus.o_miso     = miso;
  assign bus.o_miso_en  = (state == ST_ACTIVE);
  assign bus.o_busy     = (state == ST_ACTIVE);
  assign bus.o_tx_rdy   = ~tx_full;
  assign bus.o_rx_data  = rx_data;
  assign bus.o_rx_valid = rx_valid;
  assign bus.o_underrun = underrun;

endmodule

// File: tb/tb_spi_slave_core.sv
// Self-checking bench for spi_slave_core: behavioural SPI master, host TX writer and
// a word-level reference model of what each frame must exchange.
module tb_spi_slave_core;

  localparam int DW   = 8;
  localparam int HALF = 80;  // SCLK half period: 8 system clocks

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_slave_core_if #(.DATA_WIDTH(DW)) bus ();

  spi_slave_core #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rx_q[$];   // every o_rx_data seen with o_rx_valid
  int         und_q[$];  // words completed so far at each o_underrun pulse

  always @(negedge clk) begin
    if (bus.o_rx_valid) rx_q.push_back(bus.o_rx_data);
    if (bus.o_underrun) und_q.push_back(rx_q.size());
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    while (!bus.o_tx_rdy && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("tx_rdy_before_write", bus.o_tx_rdy, 1);
    bus.i_tx_data  = d;
    bus.i_tx_valid = 1'b1;
    @(negedge clk);
    bus.i_tx_valid = 1'b0;
  endtask

  // Behavioural SPI master; abort_bits>0 drops SS_n after that many bits.
  task automatic spi_frame(input bit cpol, input bit cpha, input int nwords, input int abort_bits,
                           input logic [7:0] mo[4], output logic [7:0] mi[4]);
    int total = (abort_bits > 0) ? abort_bits : nwords * 8;
    for (int j = 0; j < 4; j++) mi[j] = 8'h00;
    bus.i_cpol = cpol;
    bus.i_cpha = cpha;
    bus.i_sclk = cpol;
    #(HALF);
    bus.i_ss_n = 1'b0;
    for (int b = 0; b < total; b++) begin
      int w = b / 8;
      int i = 7 - (b % 8);
      if (!cpha) begin
        bus.i_mosi = mo[w][i];
        #(HALF);
        bus.i_sclk = ~cpol;
        mi[w][i] = bus.o_miso;
        #(HALF);
        bus.i_sclk = cpol;
      end else begin
        #(HALF);
        bus.i_sclk = ~cpol;
        bus.i_mosi = mo[w][i];
        #(HALF);
        bus.i_sclk = cpol;
        mi[w][i] = bus.o_miso;
      end
      if (b == 0) begin
        check("busy_in_frame", bus.o_busy, 1);
        check("miso_en_in_frame", bus.o_miso_en, 1);
      end
    end
    #(HALF);
    bus.i_ss_n = 1'b1;
    #(2 * HALF);
  endtask

  // One select window plus host writes, judged against the word-level model:
  // MISO word k is the word written for it, or zero if none was; every word
  // completion (and the select itself) loads the buffer, so an empty load underruns.
  task automatic run_frame(input string name, input bit cpol, input bit cpha, input int n,
                           input int abort_bits, input logic [7:0] mo[4],
                           input logic [7:0] tx[4], input bit have[4]);
    logic [7:0] mi[4];
    int rx_base  = rx_q.size();
    int und_base = und_q.size();
    int exp_und[$];
    int nrx    = (abort_bits > 0) ? 0 : n;
    int nloads = (abort_bits > 0) ? 1 : n + 1;
    if (have[0]) host_write(tx[0]);
    fork
      spi_frame(cpol, cpha, n, abort_bits, mo, mi);
      begin
        for (int k = 1; k < n; k++) begin
          if (have[k]) begin
            int t = 0;
            while ((bus.i_ss_n || (rx_q.size() - rx_base) < k - 1) && t < 20000) begin
              @(negedge clk);
              t++;
            end
            check($sformatf("%s_wr_sync%0d", name, k), (t < 20000), 1);
            repeat (8) @(negedge clk);
            host_write(tx[k]);
          end
        end
      end
    join

    if (abort_bits == 0)
      for (int w = 0; w < n; w++)
        check($sformatf("%s_miso%0d", name, w), mi[w], have[w] ? tx[w] : 8'h00);

    check($sformatf("%s_rx_count", name), rx_q.size() - rx_base, nrx);
    for (int w = 0; w < nrx && rx_base + w < rx_q.size(); w++)
      check($sformatf("%s_rx%0d", name, w), rx_q[rx_base + w], mo[w]);
    if (nrx > 0) check($sformatf("%s_rx_data", name), bus.o_rx_data, mo[n-1]);

    for (int k = 0; k < nloads; k++)
      if (k == n || !have[k]) exp_und.push_back(k);
    check($sformatf("%s_und_count", name), und_q.size() - und_base, exp_und.size());
    for (int u = 0; u < exp_und.size() && und_base + u < und_q.size(); u++)
      check($sformatf("%s_und_at%0d", name, u), und_q[und_base + u] - rx_base, exp_und[u]);

    check($sformatf("%s_tx_rdy_end", name), bus.o_tx_rdy, 1);
    check($sformatf("%s_busy_end", name), bus.o_busy, 0);
    check($sformatf("%s_miso_en_end", name), bus.o_miso_en, 0);
    check($sformatf("%s_miso_end", name), bus.o_miso, 0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"}, bus.o_miso, 0);
    check({name, "_miso_en"}, bus.o_miso_en, 0);
    check({name, "_tx_rdy"}, bus.o_tx_rdy, 1);
    check({name, "_rx_data"}, bus.o_rx_data, 0);
    check({name, "_rx_valid"}, bus.o_rx_valid, 0);
    check({name, "_underrun"}, bus.o_underrun, 0);
    check({name, "_busy"}, bus.o_busy, 0);
  endtask

  logic [7:0] mo[4], tx[4], mi_dummy[4];
  bit         have[4];
  int         rx_mark;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    rst            = 1'b0;
    bus.i_cpol     = 1'b0;
    bus.i_cpha     = 1'b0;
    bus.i_sclk     = 1'b0;
    bus.i_ss_n     = 1'b1;
    bus.i_mosi     = 1'b0;
    bus.i_tx_data  = '0;
    bus.i_tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // T1 / T2: 0xA5 out, 0x3C in, every mode
    for (int m = 0; m < 4; m++) begin
      mo   = '{8'h3C, 8'h00, 8'h00, 8'h00};
      tx   = '{8'hA5, 8'h00, 8'h00, 8'h00};
      have = '{1'b1, 1'b0, 1'b0, 1'b0};
      run_frame($sformatf("mode%0d", m), m[1], m[0], 1, 0, mo, tx, have);
    end

    // T3: two-word burst, second word written while the first is shifting
    mo   = '{8'h5A, 8'hC3, 8'h00, 8'h00};
    tx   = '{8'h11, 8'h22, 8'h00, 8'h00};
    have = '{1'b1, 1'b1, 1'b0, 1'b0};
    run_frame("burst_m0", 1'b0, 1'b0, 2, 0, mo, tx, have);
    run_frame("burst_m3", 1'b1, 1'b1, 2, 0, mo, tx, have);

    // T4: no TX write at select
    mo   = '{8'hFF, 8'h00, 8'h00, 8'h00};
    have = '{1'b0, 1'b0, 1'b0, 1'b0};
    run_frame("underrun", 1'b0, 1'b0, 1, 0, mo, tx, have);

    // T5: abort after 5 bits, then a clean word
    mo   = '{8'hE7, 8'h00, 8'h00, 8'h00};
    tx   = '{8'hA5, 8'h00, 8'h00, 8'h00};
    have = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame("abort", 1'b0, 1'b1, 1, 5, mo, tx, have);
    mo   = '{8'h81, 8'h00, 8'h00, 8'h00};
    tx   = '{8'h6B, 8'h00, 8'h00, 8'h00};
    run_frame("after_abort", 1'b0, 1'b1, 1, 0, mo, tx, have);

    // T6: reset in the middle of a word
    mo      = '{8'h3C, 8'h00, 8'h00, 8'h00};
    rx_mark = rx_q.size();
    host_write(8'h96);
    fork
      spi_frame(1'b0, 1'b0, 1, 0, mo, mi_dummy);
      begin
        repeat (60) @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_outputs("midreset");
      end
    join
    check("midreset_no_rx", rx_q.size() - rx_mark, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_tx_rdy", bus.o_tx_rdy, 1);
    check("post_reset_busy", bus.o_busy, 0);
    tx   = '{8'hC9, 8'h00, 8'h00, 8'h00};
    have = '{1'b1, 1'b0, 1'b0, 1'b0};
    run_frame("post_reset", 1'b0, 1'b0, 1, 0, mo, tx, have);

    // Randomized frames: random mode, length, data and TX-write pattern
    for (int it = 0; it < 12; it++) begin
      bit cpol = 1'($urandom_range(0, 1));
      bit cpha = 1'($urandom_range(0, 1));
      int n    = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) begin
        mo[j]   = 8'($urandom);
        tx[j]   = 8'($urandom);
        have[j] = ($urandom_range(0, 3) != 0);
      end
      run_frame($sformatf("rnd%0d", it), cpol, cpha, n, 0, mo, tx, have);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
